udp_tx_arbiter: RTL and testbench
=================================

// Module: udp_tx_arbiter
// PURPOSE
// Round-robin scheduler that shares one UDP_encoder between N_CH payload sources.
// Grants one requester at a time and latches its header (ports, length, no_chksum).
// Streams the granted source's 32-bit payload words into the encoder with start/data_av sequencing.
// Waits for encoder fin, with a timeout, before releasing the encoder.
// PARAMETERS
// N_CH         2   number of requesting channels (>=2)
// FIN_TIMEOUT  64  max cycles in WAIT_FIN before abort (>=2)
// PORTS
// clk             in   1       system clock, rising edge
// reset           in   1       synchronous, active-low reset
// ch_req          in   N_CH    per-channel packet request (level)
// ch_src_port     in   16*N_CH channel i at [16i+15:16i]
// ch_dest_port    in   16*N_CH as above
// ch_len          in   16*N_CH payload length in bytes
// ch_no_chksum    in   N_CH    per-channel checksum disable
// ch_data         in   32*N_CH payload word; first byte in [31:24]
// ch_data_valid   in   N_CH    word valid
// ch_data_ready   out  N_CH    word accepted when valid&ready
// ch_grant        out  N_CH    one-hot owner, 0 when idle
// enc_src_port    out  16      to encoder src_port
// enc_dest_port   out  16      to encoder dest_port
// enc_len         out  16      to encoder len_in
// enc_no_chksum   out  1       to encoder no_chksum
// enc_start       out  1       to encoder start
// enc_data_av     out  1       to encoder data_av
// enc_data        out  32      to encoder data
// enc_fin         in   1       from encoder fin
// busy            out  1       state != IDLE
// done            out  1       1-cycle pulse, packet completed with fin
// timeout_err     out  1       1-cycle pulse, fin not seen in time
// BEHAVIOUR
// - Reset (reset==0 at posedge): state IDLE. All outputs 0. rr pointer 0. Word counter 0.
//   Reset overrides any state, including mid-packet.
// - FSM states: IDLE, SEND, WAIT_FIN.
// - IDLE -> SEND when any ch_req is high.
//   Winner = first requesting channel at or after rr pointer, scanning upward with wrap.
//   Next cycle: ch_grant one-hot, enc_src_port/dest/len/no_chksum hold the winner's values.
//   Header is latched once and is stable until the next grant.
// - words = (len+3)>>2, computed in 17-bit arithmetic. len=65535 gives 16384 words.
// - SEND: ch_data_ready[g] = 1 while words remain. All other ready bits are 0.
//   A transfer happens on a cycle where ch_data_valid[g] & ch_data_ready[g].
//   The cycle after a transfer: enc_data_av=1 and enc_data = the transferred word.
//   enc_start=1 together with the first word only. Registered outputs give 1-cycle latency.
//   valid low (stall) gives enc_data_av=0 and enc_data holding its value. Stalls of any length are legal.
//   Bytes past len in the last word are passed through unmodified.
// - SEND -> WAIT_FIN on the cycle of the last transfer. ready drops the next cycle.
// - len=0: SEND issues one enc_start pulse with enc_data_av=0, asserts no ready, then goes to WAIT_FIN.
// - WAIT_FIN: count cycles from entry.
//   If enc_fin=1: done pulses the next cycle, ch_grant clears, rr = g+1 mod N_CH, go to IDLE.
//   If count reaches FIN_TIMEOUT without fin: timeout_err pulses instead. Grant, rr and state update identically.
//   fin and timeout in the same cycle: fin wins.
// - enc_fin in IDLE or SEND is ignored.
// - ch_req is sampled only in IDLE. Deasserting it mid-packet does not abort the packet.
// - A request held continuously is regranted only after the other requesters are served.
// - IDLE needs one cycle, so back-to-back packets have at least one idle cycle between them.
// TESTING
// 1 reset=0 for 2 cycles, ch_req=2'b11 -> all outputs 0. After release, ch0 is granted first.
// 2 ch0 len=11, "Hello World", no stalls ->
//   enc_data = 48656c6c, 6f20576f, 726c6400.
//   enc_start on the first word only, enc_data_av high for 3 cycles.
//   enc_fin -> done pulse, grant cleared.
// 3 As test 2, with valid low for 2 cycles after word 1 ->
//   enc_data_av 0 for 2 cycles, enc_data held, word count still 3.
// 4 ch0 and ch1 both request continuously -> grants alternate 0,1,0,1 and never overlap.
// 5 Granted packet, enc_fin never arrives -> timeout_err pulses FIN_TIMEOUT cycles after WAIT_FIN entry, then IDLE.
// 6 len=0 -> single enc_start with enc_data_av=0. Also: reset=0 mid-SEND -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP encoder between N_CH payload sources.
// Latches the winner's header, streams its words with start/data_av, then waits for fin.
module udp_tx_arbiter #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned FIN_TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_CH-1:0]      ch_req_i,
    input  logic [16*N_CH-1:0]   ch_src_port_i,
    input  logic [16*N_CH-1:0]   ch_dest_port_i,
    input  logic [16*N_CH-1:0]   ch_len_i,
    input  logic [N_CH-1:0]      ch_no_chksum_i,
    input  logic [32*N_CH-1:0]   ch_data_i,
    input  logic [N_CH-1:0]      ch_data_valid_i,
    output logic [N_CH-1:0]      ch_data_ready_o,
    output logic [N_CH-1:0]      ch_grant_o,
    output logic [15:0]          enc_src_port_o,
    output logic [15:0]          enc_dest_port_o,
    output logic [15:0]          enc_len_o,
    output logic                 enc_no_chksum_o,
    output logic                 enc_start_o,
    output logic                 enc_data_av_o,
    output logic [31:0]          enc_data_o,
    input  logic                 enc_fin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_err_o
);

    localparam int unsigned IdxW = $clog2(N_CH);
    localparam int unsigned CntW = $clog2(FIN_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSend, StWaitFin} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [IdxW-1:0]   gidx_q, gidx_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [15:0]       src_q, src_d;
    logic [15:0]       dest_q, dest_d;
    logic [15:0]       len_q, len_d;
    logic              nochk_q, nochk_d;
    logic [14:0]       words_q, words_d;
    logic              first_q, first_d;
    logic              start_q, start_d;
    logic              av_q, av_d;
    logic [31:0]       data_q, data_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;

    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW:0]     cand_sum;
    logic [IdxW-1:0]   cand;
    logic [15:0]       win_len;
    logic              sel_valid;
    logic [31:0]       sel_data;

    // First requester at or after the round-robin pointer, wrapping upward.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand_sum = {1'b0, rr_q} + (IdxW+1)'(i);
            if (cand_sum >= (IdxW+1)'(N_CH)) begin
                cand_sum = cand_sum - (IdxW+1)'(N_CH);
            end
            cand = cand_sum[IdxW-1:0];
            if (!win_found && ch_req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_len   = ch_len_i[16*win_idx +: 16];
    assign sel_valid = ch_data_valid_i[gidx_q];
    assign sel_data  = ch_data_i[32*gidx_q +: 32];

    always_comb begin
        ch_data_ready_o = '0;
        if (state_q == StSend && words_q != '0) begin
            ch_data_ready_o = grant_q;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        src_d   = src_q;
        dest_d  = dest_q;
        len_d   = len_q;
        nochk_d = nochk_q;
        words_d = words_q;
        first_d = first_q;
        start_d = 1'b0;
        av_d    = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StSend;
                    gidx_d  = win_idx;
                    grant_d = N_CH'(1) << win_idx;
                    src_d   = ch_src_port_i[16*win_idx +: 16];
                    dest_d  = ch_dest_port_i[16*win_idx +: 16];
                    len_d   = win_len;
                    nochk_d = ch_no_chksum_i[win_idx];
                    // 17-bit sum so len=65535 rounds up to 16384 words.
                    words_d = 15'(({1'b0, win_len} + 17'd3) >> 2);
                    first_d = 1'b1;
                end
            end
            StSend: begin
                if (words_q == '0) begin
                    // Zero-length packet: header-only start pulse.
                    start_d = 1'b1;
                    first_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StWaitFin;
                end else if (sel_valid) begin
                    av_d    = 1'b1;
                    start_d = first_q;
                    first_d = 1'b0;
                    data_d  = sel_data;
                    words_d = words_q - 15'd1;
                    if (words_q == 15'd1) begin
                        cnt_d   = '0;
                        state_d = StWaitFin;
                    end
                end
            end
            StWaitFin: begin
                if (enc_fin_i || cnt_q == CntW'(FIN_TIMEOUT - 1)) begin
                    done_d  = enc_fin_i;
                    tmo_d   = !enc_fin_i;
                    grant_d = '0;
                    rr_d    = (gidx_q == IdxW'(N_CH - 1)) ? '0 : gidx_q + IdxW'(1);
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rr_q    <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            src_q   <= '0;
            dest_q  <= '0;
            len_q   <= '0;
            nochk_q <= 1'b0;
            words_q <= '0;
            first_q <= 1'b0;
            start_q <= 1'b0;
            av_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            nochk_q <= nochk_d;
            words_q <= words_d;
            first_q <= first_d;
            start_q <= start_d;
            av_q    <= av_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ch_grant_o      = grant_q;
    assign enc_src_port_o  = src_q;
    assign enc_dest_port_o = dest_q;
    assign enc_len_o       = len_q;
    assign enc_no_chksum_o = nochk_q;
    assign enc_start_o     = start_q;
    assign enc_data_av_o   = av_q;
    assign enc_data_o      = data_q;
    assign busy_o          = (state_q != StIdle);
    assign done_o          = done_q;
    assign timeout_err_o   = tmo_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: directed cases plus randomized packets against a
// packet-level reference model (round-robin winner, word count, fin/timeout).
module tb_udp_tx_arbiter;

    localparam int N  = 2;
    localparam int FT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [16*N-1:0] src, dest, len;
    logic [N-1:0]  nochk;
    logic [32*N-1:0] data;
    logic [N-1:0]  valid;
    logic [N-1:0]  ready;
    logic [N-1:0]  grant;
    logic [15:0]   enc_src, enc_dest, enc_len;
    logic          enc_nochk, enc_start, enc_av;
    logic [31:0]   enc_data;
    logic          fin;
    logic          busy, done, tmo;

    udp_tx_arbiter #(.N_CH(N), .FIN_TIMEOUT(FT)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ch_req_i        (req),
        .ch_src_port_i   (src),
        .ch_dest_port_i  (dest),
        .ch_len_i        (len),
        .ch_no_chksum_i  (nochk),
        .ch_data_i       (data),
        .ch_data_valid_i (valid),
        .ch_data_ready_o (ready),
        .ch_grant_o      (grant),
        .enc_src_port_o  (enc_src),
        .enc_dest_port_o (enc_dest),
        .enc_len_o       (enc_len),
        .enc_no_chksum_o (enc_nochk),
        .enc_start_o     (enc_start),
        .enc_data_av_o   (enc_av),
        .enc_data_o      (enc_data),
        .enc_fin_i       (fin),
        .busy_o          (busy),
        .done_o          (done),
        .timeout_err_o   (tmo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          rr_m = 0;
    logic [31:0] last_word_m = '0;
    logic [31:0] pay[$];
    logic [31:0] out_q[$];
    int          last_g = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int winner(input logic [N-1:0] r, input int rr);
        for (int i = 0; i < N; i++) begin
            if (r[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_ready"}, 32'(ready), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_start"}, 32'(enc_start), 32'h0);
        check({tag, "_av"}, 32'(enc_av), 32'h0);
        check({tag, "_data"}, enc_data, 32'h0);
        check({tag, "_hdr"}, {enc_src, enc_dest}, 32'h0);
        check({tag, "_len"}, {15'h0, enc_nochk, enc_len}, 32'h0);
        check({tag, "_done"}, {31'h0, done | tmo}, 32'h0);
    endtask

    // Called at a negedge with the DUT idle. stall_mode: 0 always valid,
    // 1 random valid, 2 valid low for two cycles after the first word.
    task automatic run_packet(input logic [N-1:0] r, input int stall_mode, input bit use_fin,
                              input int fin_k, input int abort_at);
        int g, words, rem, sent, stall_left, cyc, k;
        bit first, pend_av, pend_start, exit_next, v;
        logic [15:0] e_src, e_dest, e_len;
        logic        e_nochk;
        logic [N-1:0] g_oh;

        g = winner(r, rr_m);
        e_src   = src[16*g +: 16];
        e_dest  = dest[16*g +: 16];
        e_len   = len[16*g +: 16];
        e_nochk = nochk[g];
        words   = (int'(e_len) + 3) / 4;
        g_oh    = N'(1) << g;
        req   = r;
        fin   = 1'($urandom_range(0, 1));
        valid = '0;
        tick();
        last_g = g;
        out_q.delete();
        check("grant", 32'(grant), 32'(g_oh));
        check("busy_send", 32'(busy), 32'h1);
        check("pulse_clear", {30'h0, done, tmo}, 32'h0);
        // Header must be latched, not follow the inputs.
        req   = N'($urandom_range(0, 3));
        src   = {$urandom, $urandom};
        dest  = {$urandom, $urandom};
        nochk = N'($urandom);

        rem = words; sent = 0; stall_left = 0;
        first = 1'b1; pend_av = 1'b0; pend_start = 1'b0; exit_next = 1'b0;
        for (cyc = 0; cyc < 40000; cyc++) begin
            check("av", 32'(enc_av), 32'(pend_av));
            check("start", 32'(enc_start), 32'(pend_start));
            check("data", enc_data, last_word_m);
            check("ready", 32'(ready), rem > 0 ? 32'(g_oh) : 32'h0);
            check("grant_hold", 32'(grant), 32'(g_oh));
            check("hdr", {enc_src, enc_dest}, {e_src, e_dest});
            check("len", {15'h0, enc_nochk, enc_len}, {15'h0, e_nochk, e_len});
            if (pend_av) out_q.push_back(enc_data);
            if (exit_next) break;
            if (abort_at == cyc) begin
                rst_n = 1'b0;
                tick();
                check_all_zero("abort");
                rst_n = 1'b1;
                rr_m = 0;
                last_word_m = '0;
                valid = '0;
                return;
            end
            pend_av = 1'b0;
            pend_start = 1'b0;
            data  = {$urandom, $urandom};
            valid = N'($urandom);
            if (rem == 0 && first) begin
                pend_start = 1'b1;
                first = 1'b0;
                exit_next = 1'b1;
            end else if (rem > 0) begin
                case (stall_mode)
                    0: v = 1'b1;
                    1: v = 1'($urandom_range(0, 1));
                    default: begin
                        if (stall_left > 0) begin
                            v = 1'b0;
                            stall_left--;
                        end else begin
                            v = 1'b1;
                        end
                    end
                endcase
                valid[g] = v;
                if (sent < pay.size()) data[32*g +: 32] = pay[sent];
                if (v) begin
                    pend_av = 1'b1;
                    pend_start = first;
                    first = 1'b0;
                    last_word_m = data[32*g +: 32];
                    sent++;
                    rem--;
                    if (sent == 1 && stall_mode == 2) stall_left = 2;
                    if (rem == 0) exit_next = 1'b1;
                end
            end
            fin = 1'($urandom_range(0, 1));
            tick();
        end
        if (!exit_next) begin
            check("send_bound", 32'h0, 32'h1);
            return;
        end
        check("word_count", 32'(out_q.size()), 32'(words));

        // Now in the first WAIT_FIN cycle.
        valid = '0;
        for (k = 0; k < FT; k++) begin
            check("wait_busy", 32'(busy), 32'h1);
            check("wait_grant", 32'(grant), 32'(g_oh));
            check("wait_pulse", {30'h0, done, tmo}, 32'h0);
            check("wait_ready", 32'(ready), 32'h0);
            if (k > 0) check("wait_av", 32'(enc_av), 32'h0);
            fin = use_fin && (k == fin_k);
            tick();
            if (fin) break;
        end
        fin = 1'b0;
        check("end_done", 32'(done), 32'(use_fin));
        check("end_tmo", 32'(tmo), 32'(!use_fin));
        check("end_grant", 32'(grant), 32'h0);
        check("end_busy", 32'(busy), 32'h0);
        check("end_hdr", {enc_src, enc_dest}, {e_src, e_dest});
        rr_m = (g + 1) % N;
    endtask

    initial begin
        string        msg;
        logic [31:0]  hw[3];
        logic [31:0]  w;
        int           l;
        hw[0] = 32'h48656c6c;
        hw[1] = 32'h6f20576f;
        hw[2] = 32'h726c6400;

        rst_n = 1'b0;
        req = 2'b11;
        src = {16'h1111, 16'h2222};
        dest = {16'h3333, 16'h4444};
        len = {16'd8, 16'd11};
        nochk = 2'b01;
        data = '0;
        valid = '0;
        fin = 1'b1;
        @(negedge clk);
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // "Hello World" on ch0 with both channels requesting
        msg = "Hello World";
        pay.delete();
        for (int i = 0; i < 3; i++) begin
            w = '0;
            for (int b = 0; b < 4; b++) begin
                if (4*i + b < msg.len()) w[31-8*b -: 8] = msg[4*i + b];
            end
            pay.push_back(w);
        end
        run_packet(2'b11, 0, 1'b1, 2, -1);
        check("hello_first_ch", 32'(last_g), 32'h0);
        check("hello_nwords", 32'(out_q.size()), 32'h3);
        for (int i = 0; i < 3 && i < out_q.size(); i++) check("hello_word", out_q[i], hw[i]);

        // Same payload with a two-cycle stall after word 1
        len = {16'd8, 16'd11};
        src = {16'h5555, 16'h6666};
        run_packet(2'b01, 2, 1'b1, 0, -1);
        check("stall_nwords", 32'(out_q.size()), 32'h3);
        for (int i = 0; i < 3 && i < out_q.size(); i++) check("stall_word", out_q[i], hw[i]);
        pay.delete();

        // Idle cycles: fin ignored, nothing granted
        req = '0;
        for (int i = 0; i < 3; i++) begin
            fin = 1'($urandom_range(0, 1));
            tick();
            check("idle_grant", 32'(grant), 32'h0);
            check("idle_pulse", {30'h0, done, tmo}, 32'h0);
        end
        fin = 1'b0;

        // Alternation from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rr_m = 0;
        last_word_m = '0;
        for (int i = 0; i < 4; i++) begin
            len = {16'(i + 5), 16'(i + 1)};
            run_packet(2'b11, 1, 1'b1, i, -1);
            check("alt_order", 32'(last_g), 32'(i % 2));
        end

        // Timeout, zero-length, mid-SEND reset
        len = {16'd4, 16'd7};
        run_packet(2'b11, 0, 1'b0, 0, -1);
        len = {16'd0, 16'd0};
        run_packet(2'b11, 0, 1'b1, FT - 1, -1);
        check("zero_len_words", 32'(out_q.size()), 32'h0);
        len = {16'd40, 16'd40};
        run_packet(2'b11, 0, 1'b1, 1, 5);
        len = {16'd3, 16'd2};
        run_packet(2'b11, 0, 1'b1, 0, -1);
        check("after_abort_ch", 32'(last_g), 32'h0);

        // Maximum length
        len = {16'd65535, 16'd1};
        run_packet(2'b10, 0, 1'b1, 3, -1);
        check("max_len_words", 32'(out_q.size()), 32'd16384);

        // Randomized packets
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N; c++) begin
                l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 60);
                len[16*c +: 16] = 16'(l);
            end
            src   = {$urandom, $urandom};
            dest  = {$urandom, $urandom};
            nochk = N'($urandom);
            run_packet(N'($urandom_range(1, 3)), $urandom_range(0, 1),
                       $urandom_range(0, 4) != 0, $urandom_range(0, FT - 1), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
